nv_ram_fifo_ctrl_160x65: RTL

NV_RAM_FIFO_CTRL_160X65 -- requirements
Module: nv_ram_fifo_ctrl_160x65

---
 rtl/nv_ram_fifo_ctrl_160x65_pkg.sv | 21 ++
 rtl/nv_ram_fifo_ctrl_160x65_oq3.sv | 62 ++++++
 rtl/nv_ram_fifo_ctrl_160x65.sv | 102 ++++++++++
 3 files changed

// File: rtl/nv_ram_fifo_ctrl_160x65_pkg.sv
// Shared constants and helpers for the 160x65 RAM-backed FIFO controller.
package nv_ram_fifo_ctrl_160x65_pkg;

  localparam int unsigned DEPTH    = 160;
  localparam int unsigned WIDTH    = 65;
  localparam int unsigned AW       = 8;
  localparam int unsigned OQ_DEPTH = 3;
  localparam int unsigned CNT_W    = 9;
  localparam int unsigned PWR_W    = 32;
  localparam int unsigned OQ_PW    = 2;
  localparam int unsigned OQ_CW    = 2;
  localparam int unsigned CREDIT_W = 3;

  typedef logic [OQ_PW-1:0] oq_ptr_t;

  // Modulo-3 increment for the output-queue pointers.
  function automatic oq_ptr_t oq_ptr_inc(input oq_ptr_t p);
    return (p == OQ_PW'(OQ_DEPTH - 1)) ? '0 : p + OQ_PW'(1);
  endfunction

endpackage

// File: rtl/nv_ram_fifo_ctrl_160x65_oq3.sv
// Three-entry output queue; head payload and valid are registered and
// the payload holds its last value while the queue is empty.
module nv_fifo_ctrl_oq3
  import nv_ram_fifo_ctrl_160x65_pkg::*;
#(
  parameter int unsigned PD_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PD_W-1:0]  push_pd,
  input  logic             pop,
  output logic [OQ_CW-1:0] cnt,
  output logic             head_vld,
  output logic [PD_W-1:0]  head_pd
);

  logic [PD_W-1:0]  mem [OQ_DEPTH];
  oq_ptr_t          wr_ptr;
  oq_ptr_t          rd_ptr;
  oq_ptr_t          rd_ptr_nxt;
  logic             pop_ok;
  logic [OQ_CW-1:0] cnt_after_pop;
  logic [OQ_CW-1:0] cnt_nxt;
  logic [PD_W-1:0]  head_nxt;

  // Next head: the pushed word bypasses the array when the queue drains to empty.
  always_comb begin
    pop_ok        = pop && (cnt != '0);
    rd_ptr_nxt    = pop_ok ? oq_ptr_inc(rd_ptr) : rd_ptr;
    cnt_after_pop = cnt - OQ_CW'(pop_ok);
    cnt_nxt       = cnt_after_pop + OQ_CW'(push);
    head_nxt      = (cnt_after_pop == '0) ? push_pd : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_pd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      head_vld <= 1'b0;
      head_pd  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= oq_ptr_inc(wr_ptr);
      end
      rd_ptr   <= rd_ptr_nxt;
      cnt      <= cnt_nxt;
      head_vld <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        head_pd <= head_nxt;
      end
    end
  end

endmodule

// File: rtl/nv_ram_fifo_ctrl_160x65.sv
// Controller for a FIFO built on an external 2-cycle-read RAM, with a
// credit-checked 3-entry output queue absorbing the read latency.
module nv_ram_fifo_ctrl_160x65
  import nv_ram_fifo_ctrl_160x65_pkg::*;
#(
  parameter int unsigned DEPTH = nv_ram_fifo_ctrl_160x65_pkg::DEPTH,
  parameter int unsigned WIDTH = nv_ram_fifo_ctrl_160x65_pkg::WIDTH
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [CNT_W-1:0] fifo_cnt,
  input  logic [PWR_W-1:0] pwrbus_ram_pd,
  output logic [PWR_W-1:0] ram_pwrbus_ram_pd
);

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CNT_W-1:0]    ram_cnt;
  logic                p1;
  logic                p2;
  logic [OQ_CW-1:0]    oq_cnt;
  logic                wr_acc;
  logic                rd_iss;
  logic                oq_pop;
  logic [CREDIT_W-1:0] credit_used;

  // Credits count a word that pops this cycle as already gone, so a full
  // pipe can still issue one read per cycle without overrunning the queue.
  always_comb begin
    wr_prdy     = (ram_cnt != CNT_W'(DEPTH));
    wr_acc      = wr_pvld && wr_prdy && nvdla_core_rstn;
    oq_pop      = rd_pvld && rd_prdy;
    credit_used = CREDIT_W'(p1) + CREDIT_W'(p2) + CREDIT_W'(oq_cnt) - CREDIT_W'(oq_pop);
    rd_iss      = (ram_cnt != '0) && (credit_used < CREDIT_W'(OQ_DEPTH));
  end

  always_comb begin
    ram_we            = wr_acc;
    ram_wa            = wr_ptr;
    ram_di            = wr_pd;
    ram_re            = rd_iss;
    ram_ra            = rd_ptr;
    ram_ore           = p1;
    fifo_cnt          = ram_cnt + CNT_W'(p1) + CNT_W'(p2) + CNT_W'(oq_cnt);
    ram_pwrbus_ram_pd = pwrbus_ram_pd;
  end

  // RAM pointers and occupancy; ram_cnt only ever reflects committed writes.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (rd_iss) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      ram_cnt <= ram_cnt + CNT_W'(wr_acc) - CNT_W'(rd_iss);
    end
  end

  // Read-latency tracking: p1 = address registered, p2 = data out registered.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p1 <= rd_iss;
      p2 <= p1;
    end
  end

  nv_fifo_ctrl_oq3 #(
    .PD_W (WIDTH)
  ) u_oq (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .push     (p2),
    .push_pd  (ram_dout),
    .pop      (oq_pop),
    .cnt      (oq_cnt),
    .head_vld (rd_pvld),
    .head_pd  (rd_pd)
  );

endmodule
